// File: rtl/riscy_mem_pkg.sv
// rtl/riscy_mem_pkg.sv - shared types and constants for the RISCY memory-port arbiter
//
// Purpose : source identifier type, the width helper for the outstanding
//           counter, and the fixed fields an instruction fetch presents to memory.
// Ports   : none (package)
package riscy_mem_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    // Fetches are always full-word reads.
    localparam logic [3:0] INSTR_BE    = 4'hF;
    // Replicated to the data bus width where used.
    localparam logic       INSTR_WDATA = 1'b0;

    // The counter must be able to hold the value "depth" itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/riscy_src_fifo.sv
// rtl/riscy_src_fifo.sv - in-order FIFO of source IDs for outstanding memory transactions
//
// Purpose : remembers which port issued each granted transaction so the
//           in-order responses can be steered back to it.
// Ports   : clk_i, rst_ni        clock, asynchronous active-low reset
//           push_i, push_src_i   enqueue a source ID (ignored when full)
//           pop_i                dequeue the head (ignored when empty)
//           head_o               oldest outstanding source
//           full_o, empty_o      occupancy flags
//           count_o              number of entries held
module riscy_src_fifo
    import riscy_mem_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = cnt_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  src_e          push_src_i,
    input  logic          pop_i,
    output src_e          head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    src_e          mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    // No full bypass: a pop frees a slot for the following cycle only.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= SRC_INSTR;
            end
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= push_src_i;
            end
        end
    end

endmodule

// File: rtl/riscy_mem_arbiter.sv
// rtl/riscy_mem_arbiter.sv - round-robin sharing of one memory port between fetch and data
//
// Purpose : combinational request muxing with lock-until-grant, and response
//           steering through a source-ID FIFO.
// Ports   : clk_i, rst_ni                      clock, asynchronous active-low reset
//           instr_req/addr_i, instr_gnt/rvalid/rdata_o      fetch port
//           data_req/we/be/addr/wdata_i, data_gnt/rvalid/rdata_o  load/store port
//           mem_req/we/be/addr/wdata_o, mem_gnt/rvalid/rdata_i    shared memory port
//           busy_o                              transactions outstanding
//           err_o                               sticky: response with nothing outstanding
module riscy_mem_arbiter
    import riscy_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);

    src_e          last_q, last_d;
    src_e          lock_src_q, lock_src_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;

    logic          win_valid;
    src_e          win_src;
    logic          win_req;
    logic          grant;
    logic          pop;

    src_e          fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // A pending (locked) request keeps the port until memory accepts it, so
    // the address seen by memory cannot change underneath it.
    always_comb begin
        win_valid = 1'b0;
        win_src   = SRC_INSTR;
        if (lock_q) begin
            win_valid = 1'b1;
            win_src   = lock_src_q;
        end else if (instr_req_i && data_req_i) begin
            win_valid = 1'b1;
            win_src   = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        end else if (data_req_i) begin
            win_valid = 1'b1;
            win_src   = SRC_DATA;
        end else if (instr_req_i) begin
            win_valid = 1'b1;
            win_src   = SRC_INSTR;
        end
    end

    assign win_req   = win_valid && ((win_src == SRC_DATA) ? data_req_i : instr_req_i);
    assign mem_req_o = win_req && !fifo_full;
    assign grant     = mem_req_o && mem_gnt_i;

    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (win_valid) begin
            if (win_src == SRC_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = INSTR_BE;
                mem_addr_o  = instr_addr_i;
                mem_wdata_o = {DATA_WIDTH{INSTR_WDATA}};
            end
        end
    end

    assign instr_gnt_o = grant && (win_src == SRC_INSTR);
    assign data_gnt_o  = grant && (win_src == SRC_DATA);

    // Memory answers at least one cycle after the grant, so a pop never
    // targets the entry being pushed in the same cycle.
    assign pop            = mem_rvalid_i && !fifo_empty;
    assign instr_rvalid_o = pop && (fifo_head == SRC_INSTR);
    assign data_rvalid_o  = pop && (fifo_head == SRC_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign busy_o = (fifo_count != '0);
    assign err_o  = err_q;

    // While full, mem_req_o is low, so neither branch fires and the lock holds.
    always_comb begin
        last_d     = last_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        err_d      = err_q || (mem_rvalid_i && fifo_empty);
        if (mem_req_o && !mem_gnt_i) begin
            lock_d     = 1'b1;
            lock_src_d = win_src;
        end
        if (grant) begin
            lock_d = 1'b0;
            last_d = win_src;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= SRC_INSTR;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
            err_q      <= 1'b0;
        end else begin
            last_q     <= last_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            err_q      <= err_d;
        end
    end

    riscy_src_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_src_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (grant),
        .push_src_i (win_src),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// tb/tb_riscy_mem_arbiter.sv - self-checking bench for riscy_mem_arbiter
module tb_riscy_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          instr_req_i;
    logic [AW-1:0] instr_addr_i;
    logic          instr_gnt_o;
    logic          instr_rvalid_o;
    logic [DW-1:0] instr_rdata_o;
    logic          data_req_i;
    logic          data_we_i;
    logic [3:0]    data_be_i;
    logic [AW-1:0] data_addr_i;
    logic [DW-1:0] data_wdata_i;
    logic          data_gnt_o;
    logic          data_rvalid_o;
    logic [DW-1:0] data_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;
    logic          busy_o;
    logic          err_o;

    riscy_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: 0 = fetch port, 1 = data port.
    bit m_q[$];
    bit m_last;
    bit m_lock;
    bit m_lsrc;
    bit m_err;

    always @(negedge clk_i) begin : model
        bit full, wv, ws, wreq, ereq, egrant, epop, head;
        if (!rst_ni) begin
            m_q.delete();
            m_last = 1'b0;
            m_lock = 1'b0;
            m_lsrc = 1'b0;
            m_err  = 1'b0;
        end
        full = (m_q.size() == MAXO);
        wv   = 1'b1;
        ws   = 1'b0;
        if (m_lock)                        ws = m_lsrc;
        else if (instr_req_i && data_req_i) ws = !m_last;
        else if (data_req_i)               ws = 1'b1;
        else if (instr_req_i)              ws = 1'b0;
        else                               wv = 1'b0;
        wreq   = wv && (ws ? data_req_i : instr_req_i);
        ereq   = wreq && !full;
        egrant = ereq && mem_gnt_i;
        epop   = mem_rvalid_i && (m_q.size() != 0);
        head   = (m_q.size() != 0) ? m_q[0] : 1'b0;

        chk("m_mem_req", mem_req_o, ereq);
        chk("m_mem_we", mem_we_o, wv && ws && data_we_i);
        chk("m_mem_be", mem_be_o, !wv ? 4'h0 : (ws ? data_be_i : 4'hF));
        chk("m_mem_addr", mem_addr_o, !wv ? '0 : (ws ? data_addr_i : instr_addr_i));
        chk("m_mem_wdata", mem_wdata_o, (wv && ws) ? data_wdata_i : '0);
        chk("m_instr_gnt", instr_gnt_o, egrant && !ws);
        chk("m_data_gnt", data_gnt_o, egrant && ws);
        chk("m_instr_rvalid", instr_rvalid_o, epop && !head);
        chk("m_data_rvalid", data_rvalid_o, epop && head);
        chk("m_instr_rdata", instr_rdata_o, mem_rdata_i);
        chk("m_data_rdata", data_rdata_o, mem_rdata_i);
        chk("m_busy", busy_o, m_q.size() != 0);
        chk("m_err", err_o, m_err);

        if (rst_ni) begin
            if (mem_rvalid_i && m_q.size() == 0) m_err = 1'b1;
            if (epop) void'(m_q.pop_front());
            if (egrant) begin
                m_q.push_back(ws);
                m_last = ws;
                m_lock = 1'b0;
            end else if (ereq) begin
                m_lock = 1'b1;
                m_lsrc = ws;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle();
        repeat (2) cyc();
        #3;
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_instr_gnt", instr_gnt_o, 0);
        chk("rst_data_gnt", data_gnt_o, 0);
        chk("rst_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        cyc();
        rst_ni = 1'b1;

        // Tie after reset: data first, then fetch; in-order responses.
        cyc();
        instr_req_i = 1'b1; instr_addr_i = 32'h0;
        data_req_i  = 1'b1; data_addr_i = 32'h100; data_be_i = 4'hF;
        mem_gnt_i   = 1'b1;
        #3;
        chk("s1_data_gnt", data_gnt_o, 1);
        chk("s1_instr_gnt", instr_gnt_o, 0);
        chk("s1_addr", mem_addr_o, 32'h100);
        cyc();
        data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0001;
        #3;
        chk("s1_instr_gnt2", instr_gnt_o, 1);
        chk("s1_addr2", mem_addr_o, 32'h0);
        chk("s1_data_rvalid", data_rvalid_o, 1);
        chk("s1_data_rdata", data_rdata_o, 32'hAAAA0001);
        chk("s1_instr_rvalid0", instr_rvalid_o, 0);
        cyc();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'hBBBB0002;
        #3;
        chk("s1_instr_rvalid", instr_rvalid_o, 1);
        chk("s1_instr_rdata", instr_rdata_o, 32'hBBBB0002);
        chk("s1_busy_held", busy_o, 1);
        cyc();
        idle();
        #3;
        chk("s1_busy_done", busy_o, 0);

        // Store held off for three cycles with fetch also requesting.
        cyc();
        instr_req_i = 1'b1; instr_addr_i = 32'h40;
        data_req_i  = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
        data_addr_i = 32'h20; data_wdata_i = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) cyc();
            mem_gnt_i = (k == 3);
            #3;
            chk("s2_lock_addr", mem_addr_o, 32'h20);
            chk("s2_lock_be", mem_be_o, 4'b0011);
            chk("s2_data_gnt", data_gnt_o, (k == 3));
            chk("s2_instr_gnt", instr_gnt_o, 0);
        end
        cyc();
        #3;
        chk("s2_rr_instr_gnt", instr_gnt_o, 1);
        chk("s2_rr_addr", mem_addr_o, 32'h40);
        chk("s2_rr_we", mem_we_o, 0);
        cyc();
        idle(); mem_rvalid_i = 1'b1;
        #3;
        chk("s2_data_rvalid", data_rvalid_o, 1);
        cyc();
        #3;
        chk("s2_instr_rvalid", instr_rvalid_o, 1);
        cyc();
        idle();

        // Back-pressure once MAXO transactions are outstanding.
        cyc();
        instr_req_i = 1'b1; instr_addr_i = 32'h80; mem_gnt_i = 1'b1;
        #3;
        chk("s3_gnt1", instr_gnt_o, 1);
        cyc();
        #3;
        chk("s3_gnt2", instr_gnt_o, 1);
        cyc();
        #3;
        chk("s3_full_req", mem_req_o, 0);
        chk("s3_full_gnt", instr_gnt_o, 0);
        chk("s3_full_busy", busy_o, 1);
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5;
        #3;
        chk("s3_pop_rvalid", instr_rvalid_o, 1);
        chk("s3_no_bypass", mem_req_o, 0);
        cyc();
        mem_rvalid_i = 1'b0;
        #3;
        chk("s3_reopen_req", mem_req_o, 1);
        chk("s3_reopen_gnt", instr_gnt_o, 1);
        cyc();
        idle(); mem_rvalid_i = 1'b1;
        cyc();
        cyc();
        mem_rvalid_i = 1'b0;
        #3;
        chk("s3_drained", busy_o, 0);

        // Orphan response.
        cyc();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD;
        #3;
        chk("s4_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        chk("s4_err_late", err_o, 0);
        cyc();
        mem_rvalid_i = 1'b0;
        #3;
        chk("s4_err_set", err_o, 1);
        cyc();
        #3;
        chk("s4_err_sticky", err_o, 1);

        // Reset with two outstanding; last grant is data beforehand.
        cyc();
        instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b1;
        #3;
        chk("s5_instr_gnt", instr_gnt_o, 1);
        cyc();
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h300; data_be_i = 4'hF;
        #3;
        chk("s5_data_gnt", data_gnt_o, 1);
        cyc();
        idle();
        #3;
        chk("s5_busy_pre", busy_o, 1);
        cyc();
        rst_ni = 1'b0;
        #3;
        chk("s5_rst_busy", busy_o, 0);
        chk("s5_rst_err", err_o, 0);
        cyc();
        rst_ni = 1'b1;
        cyc();
        mem_rvalid_i = 1'b1;
        #3;
        chk("s5_stale_no_rvalid", {instr_rvalid_o, data_rvalid_o}, 0);
        cyc();
        mem_rvalid_i = 1'b0;
        instr_req_i = 1'b1; instr_addr_i = 32'h400;
        data_req_i  = 1'b1; data_addr_i = 32'h500; data_be_i = 4'hF;
        mem_gnt_i   = 1'b1;
        #3;
        chk("s5_stale_err", err_o, 1);
        chk("s5_tie_data", data_gnt_o, 1);
        chk("s5_tie_addr", mem_addr_o, 32'h500);
        cyc();
        idle(); mem_rvalid_i = 1'b1;
        #3;
        chk("s5_data_rvalid", data_rvalid_o, 1);
        cyc();
        idle();
        #3;
        chk("s5_idle_busy", busy_o, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
